// File: rtl/ram_sync.sv
// Synchronous word RAM with select/ready handshake, one-cycle read latency and
// a post-reset scrub that zero-fills every word before requests are accepted.
module ram_sync #(
    parameter int word_size   = 20,
    parameter int word_amount = 30,
    parameter int addr_width  = $clog2(word_amount)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  select,
    input  logic                  operation,
    input  logic [addr_width-1:0] address,
    input  logic [word_size-1:0]  wdata,
    output logic                  ready,
    output logic [word_size-1:0]  rdata,
    output logic                  rvalid,
    output logic                  error
);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    localparam logic [addr_width-1:0] last_ptr   = addr_width'(word_amount - 1);
    // One extra bit so a power-of-two depth compares without overflow.
    localparam logic [addr_width:0]   amount_ext = (addr_width + 1)'(word_amount);

    state_t                state;
    state_t                state_next;
    logic [addr_width-1:0] ptr;
    logic [word_size-1:0]  mem [word_amount];

    logic                  accept;
    logic                  in_range;
    logic                  do_read;
    logic                  do_write;
    logic                  bad_req;

    logic                  mem_we;
    logic [addr_width-1:0] mem_waddr;
    logic [word_size-1:0]  mem_wdata;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (ptr == last_ptr) state_next = ST_IDLE;
            ST_IDLE: state_next = ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        if (state == ST_IDLE) ready = 1'b1;
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept   = select && ready;
    assign in_range = {1'b0, address} < amount_ext;
    assign do_read  = accept && !operation && in_range;
    assign do_write = accept &&  operation && in_range;
    assign bad_req  = accept && !in_range;

    // ------------------------------------------------------------------
    // Scrub pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Single write port shared by the scrubber and bus writes
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we = 1'b1;
        end else if (do_write) begin
            mem_we    = 1'b1;
            mem_waddr = address;
            mem_wdata = wdata;
        end
    end

    // NOTE: the array has no reset; the scrub after every reset gives it a
    // known value instead, keeping it mappable onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response path: rdata holds between reads, cleared by reset or error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            error  <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= do_read;
            error  <= bad_req;
            if (do_read) begin
                rdata <= mem[address];
            end else if (bad_req) begin
                rdata <= '0;
            end
        end
    end

endmodule
